// File: rtl/credit_sender.sv
// Transmit end of a credit-based push link: forwards upstream ready/valid words, one credit per word.
// Optional sticky overflow flag enabled by defining CREDIT_SENDER_OVERFLOW_EN.
module credit_sender #(
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_CREDITS  = 4,
    parameter int CREDIT_WIDTH = $clog2(MAX_CREDITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    push_valid,
    output logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    push_credit,
    output logic                    push_sender_in_reset,
    input  logic                    push_receiver_in_reset,
    input  logic [CREDIT_WIDTH-1:0] credit_initial,
    input  logic [CREDIT_WIDTH-1:0] credit_withhold,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic [CREDIT_WIDTH-1:0] credit_available
`ifdef CREDIT_SENDER_OVERFLOW_EN
    ,
    output logic                    credit_overflow
`endif
);

    typedef enum logic [1:0] {
        S_RESET,
        S_WAIT_RX,
        S_ACTIVE
    } state_e;

    localparam logic [CREDIT_WIDTH-1:0] MAX_C = CREDIT_WIDTH'(MAX_CREDITS);
    localparam logic [CREDIT_WIDTH-1:0] ONE_C = CREDIT_WIDTH'(1);

    state_e                  state_q;
    logic                    push_valid_q;
    logic [DATA_WIDTH-1:0]   push_data_q;
    logic                    sender_in_reset_q;
    logic [CREDIT_WIDTH-1:0] count_q, count_d;
    logic [CREDIT_WIDTH-1:0] init_clamped;
    logic [CREDIT_WIDTH-1:0] avail;
    logic                    fire;
    logic                    credit_in;

    assign init_clamped = (credit_initial > MAX_C) ? MAX_C : credit_initial;
    assign avail        = (count_q > credit_withhold) ? (count_q - credit_withhold) : '0;
    assign in_ready     = (state_q == S_ACTIVE) && !push_receiver_in_reset && (avail != '0);
    assign fire         = in_valid && in_ready;
    // Credits only count while the link is live; a credit at the ceiling is discarded.
    assign credit_in    = (state_q == S_ACTIVE) && !push_receiver_in_reset && push_credit;

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        if (state_q != S_ACTIVE || push_receiver_in_reset) begin
            count_d = init_clamped;
        end else if (fire && !credit_in) begin
            count_d = count_q - ONE_C;
        end else if (!fire && credit_in && count_q != MAX_C) begin
            count_d = count_q + ONE_C;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= S_RESET;
            push_valid_q      <= 1'b0;
            push_data_q       <= '0;
            sender_in_reset_q <= 1'b1;
            count_q           <= '0;
        end else begin
            count_q      <= count_d;
            push_valid_q <= fire;
            if (fire) begin
                push_data_q <= in_data;
            end
            case (state_q)
                S_RESET: begin
                    state_q           <= S_WAIT_RX;
                    sender_in_reset_q <= 1'b0;
                end
                S_WAIT_RX: begin
                    sender_in_reset_q <= 1'b0;
                    if (!push_receiver_in_reset) begin
                        state_q <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (push_receiver_in_reset) begin
                        state_q <= S_WAIT_RX;
                    end
                end
                default: begin
                    state_q           <= S_RESET;
                    sender_in_reset_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef CREDIT_SENDER_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (state_q == S_RESET) begin
            overflow_q <= 1'b0;
        end else if (credit_in && !fire && count_q == MAX_C) begin
            overflow_q <= 1'b1;
        end
    end

    assign credit_overflow = overflow_q;
`endif

    assign push_valid           = push_valid_q;
    assign push_data            = push_data_q;
    assign push_sender_in_reset = sender_in_reset_q;
    assign credit_count         = count_q;
    assign credit_available     = avail;

endmodule
